// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } dmem_state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } dmem_port_t;

    localparam int unsigned DMEM_DEPTH = 65536;
    localparam int unsigned DMEM_WAIT  = 2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the memory-side bus of the arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              a_err;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              b_err;

    logic              mem_writeS;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_dataIn;
    logic [DATA_W-1:0] mem_dataOut;

    logic              busy;

    // Arbiter side.
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_dataOut,
        output a_ack, a_rdata, a_err,
        output b_ack, b_rdata, b_err,
        output mem_writeS, mem_address, mem_dataIn,
        output busy
    );

    // Requester / memory side.
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_dataOut,
        input  a_ack, a_rdata, a_err,
        input  b_ack, b_rdata, b_err,
        input  mem_writeS, mem_address, mem_dataIn,
        input  busy
    );

endinterface

// File: rtl/dmem_rr_select.sv
// Two-way round-robin pick: on a tie the port that was not served last wins.
module dmem_rr_select
    import dmem_pkg::*;
(
    input  logic       a_req_i,
    input  logic       b_req_i,
    input  dmem_port_t rr_last_i,
    output logic       grant_o,
    output dmem_port_t owner_o
);

    // Owner choice is only meaningful while grant_o is high.
    always_comb begin
        grant_o = a_req_i | b_req_i;
        owner_o = PORT_A;
        if (a_req_i && b_req_i) begin
            owner_o = (rr_last_i == PORT_A) ? PORT_B : PORT_A;
        end else if (b_req_i) begin
            owner_o = PORT_B;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the single-port data memory.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = DMEM_DEPTH,
    parameter int unsigned WAIT_CYCLES = DMEM_WAIT
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);

    localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

    dmem_state_t       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    dmem_port_t        owner_q, owner_d;
    dmem_port_t        rr_last_q, rr_last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic              grant;
    dmem_port_t        sel_owner;
    logic              in_range;
    logic [DATA_W-1:0] captured;

    dmem_rr_select u_rr_select (
        .a_req_i   (bus.a_req),
        .b_req_i   (bus.b_req),
        .rr_last_i (rr_last_q),
        .grant_o   (grant),
        .owner_o   (sel_owner)
    );

    // Extra top bit keeps the compare correct when DEPTH == 2**ADDR_W.
    assign in_range    = ({1'b0, addr_q} < DepthW);
    assign bus.a_rdata = a_rdata_q;
    assign bus.b_rdata = b_rdata_q;
    assign bus.busy    = (state_q != IDLE);

    // State, latched request and response registers; reset aborts any open access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            owner_q   <= PORT_A;
            rr_last_q <= PORT_B;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Next-state logic plus the memory strobe and ack/err outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        captured  = '0;

        bus.mem_writeS  = 1'b0;
        bus.mem_address = '0;
        bus.mem_dataIn  = '0;
        bus.a_ack       = 1'b0;
        bus.a_err       = 1'b0;
        bus.b_ack       = 1'b0;
        bus.b_err       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = BUSY;
                    owner_d = sel_owner;
                    cnt_d   = CntW'(WAIT_CYCLES);
                    if (sel_owner == PORT_A) begin
                        we_d    = bus.a_we;
                        addr_d  = bus.a_addr;
                        wdata_d = bus.a_wdata;
                    end else begin
                        we_d    = bus.b_we;
                        addr_d  = bus.b_addr;
                        wdata_d = bus.b_wdata;
                    end
                end
            end
            BUSY: begin
                bus.mem_address = addr_q;
                bus.mem_dataIn  = wdata_q;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    // Access cycle: out-of-range requests neither write nor read.
                    bus.mem_writeS = we_q & in_range;
                    if (!we_q && in_range) begin
                        captured = bus.mem_dataOut;
                    end
                    if (owner_q == PORT_A) begin
                        a_rdata_d = captured;
                    end else begin
                        b_rdata_d = captured;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (owner_q == PORT_A) begin
                    bus.a_ack = 1'b1;
                    bus.a_err = ~in_range;
                end else begin
                    bus.b_ack = 1'b1;
                    bus.b_err = ~in_range;
                end
                rr_last_d = owner_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: stimulus pushes expected acks, per-DUT monitors pop and compare.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    typedef struct {
        bit          port;   // 0 = A, 1 = B
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int strobes2 = 0;
    int strobes0 = 0;
    exp_t q2[$];
    exp_t q0[$];

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

    dmem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .DEPTH       (DMEM_DEPTH),
        .WAIT_CYCLES (DMEM_WAIT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    dmem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .DEPTH       (DMEM_DEPTH),
        .WAIT_CYCLES (0)
    ) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    // Data memories behind each arbiter (low 8 address bits only).
    logic [31:0] mem2 [256] = '{default: 32'h0};
    logic [31:0] mem0 [256] = '{default: 32'h0};
    assign bus2.mem_dataOut = mem2[bus2.mem_address[7:0]];
    assign bus0.mem_dataOut = mem0[bus0.mem_address[7:0]];
    always @(posedge clk) if (bus2.mem_writeS) mem2[bus2.mem_address[7:0]] <= bus2.mem_dataIn;
    always @(posedge clk) if (bus0.mem_writeS) mem0[bus0.mem_address[7:0]] <= bus0.mem_dataIn;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic sb_compare(input string name, input bit a_ack, input bit b_ack,
                              input bit err, input logic [31:0] rdata, input bit empty,
                              input exp_t e);
        if (a_ack && b_ack) begin
            checks++; errors++;
            $display("FAIL %s_dual_ack: got both acks expected one", name);
        end else if (empty) begin
            checks++; errors++;
            $display("FAIL %s_unexpected_ack: got ack port=%0d expected none", name, b_ack);
        end else begin
            check(name, {29'b0, b_ack, err, rdata}, {29'b0, e.port, e.err, e.rdata});
        end
    endtask

    // Monitor for the WAIT_CYCLES=2 instance.
    always @(negedge clk) begin
        exp_t e;
        bit   empty;
        if (bus2.mem_writeS) strobes2++;
        if (bus2.a_ack || bus2.b_ack) begin
            empty = (q2.size() == 0);
            e = '{port: 1'b0, err: 1'b0, rdata: 32'h0};
            if (!empty && !(bus2.a_ack && bus2.b_ack)) e = q2.pop_front();
            sb_compare("sb2_resp", bus2.a_ack, bus2.b_ack,
                       bus2.b_ack ? bus2.b_err : bus2.a_err,
                       bus2.b_ack ? bus2.b_rdata : bus2.a_rdata, empty, e);
        end
    end

    // Monitor for the WAIT_CYCLES=0 instance.
    always @(negedge clk) begin
        exp_t e;
        bit   empty;
        if (bus0.mem_writeS) strobes0++;
        if (bus0.a_ack || bus0.b_ack) begin
            empty = (q0.size() == 0);
            e = '{port: 1'b0, err: 1'b0, rdata: 32'h0};
            if (!empty && !(bus0.a_ack && bus0.b_ack)) e = q0.pop_front();
            sb_compare("sb0_resp", bus0.a_ack, bus0.b_ack,
                       bus0.b_ack ? bus0.b_err : bus0.a_err,
                       bus0.b_ack ? bus0.b_rdata : bus0.a_rdata, empty, e);
        end
    end

    // One request on the WAIT=2 DUT; cycle numbers count negedges after the grant edge.
    task automatic run2(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input bit scramble,
                        output int ack_at, output int strobe_at);
        ack_at = -1;
        strobe_at = -1;
        if (!port) begin
            bus2.a_we = we; bus2.a_addr = addr; bus2.a_wdata = wd; bus2.a_req = 1'b1;
        end else begin
            bus2.b_we = we; bus2.b_addr = addr; bus2.b_wdata = wd; bus2.b_req = 1'b1;
        end
        @(posedge clk);
        if (scramble) begin
            #1;
            if (!port) begin
                bus2.a_we = ~we; bus2.a_addr = addr ^ 32'hFF; bus2.a_wdata = ~wd;
            end else begin
                bus2.b_we = ~we; bus2.b_addr = addr ^ 32'hFF; bus2.b_wdata = ~wd;
            end
        end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus2.mem_writeS && strobe_at < 0) strobe_at = n;
            if ((!port && bus2.a_ack) || (port && bus2.b_ack)) begin
                ack_at = n;
                break;
            end
        end
        if (ack_at < 0) begin
            checks++; errors++;
            $display("FAIL run2_timeout: got no ack expected ack within 40 cycles");
        end
        @(posedge clk);
        #1;
        if (!port) bus2.a_req = 1'b0;
        else bus2.b_req = 1'b0;
    endtask

    // One request on the WAIT=0 DUT.
    task automatic run0(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, output int ack_at);
        ack_at = -1;
        if (!port) begin
            bus0.a_we = we; bus0.a_addr = addr; bus0.a_wdata = wd; bus0.a_req = 1'b1;
        end else begin
            bus0.b_we = we; bus0.b_addr = addr; bus0.b_wdata = wd; bus0.b_req = 1'b1;
        end
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if ((!port && bus0.a_ack) || (port && bus0.b_ack)) begin
                ack_at = n;
                break;
            end
        end
        if (ack_at < 0) begin
            checks++; errors++;
            $display("FAIL run0_timeout: got no ack expected ack within 40 cycles");
        end
        @(posedge clk);
        #1;
        if (!port) bus0.a_req = 1'b0;
        else bus0.b_req = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_busy"}, {63'b0, bus2.busy}, 64'h0);
        check({name, "_ack_err_we"}, {59'b0, bus2.a_ack, bus2.b_ack, bus2.a_err, bus2.b_err,
              bus2.mem_writeS}, 64'h0);
        check({name, "_mem_bus"}, {bus2.mem_address, bus2.mem_dataIn}, 64'h0);
    endtask

    initial begin
        int ack_at, st_at, s0, ack_b;
        bus2.a_req = 0; bus2.a_we = 0; bus2.a_addr = 0; bus2.a_wdata = 0;
        bus2.b_req = 0; bus2.b_we = 0; bus2.b_addr = 0; bus2.b_wdata = 0;
        bus0.a_req = 0; bus0.a_we = 0; bus0.a_addr = 0; bus0.a_wdata = 0;
        bus0.b_req = 0; bus0.b_we = 0; bus0.b_addr = 0; bus0.b_wdata = 0;

        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        check("reset_rdata", {bus2.a_rdata, bus2.b_rdata}, 64'h0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: A write, strobe on cycle 3 after grant, ack on cycle 4.
        q2.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h0});
        s0 = strobes2;
        run2(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, ack_at, st_at);
        check("t1_strobe_cycle", 64'(st_at), 64'd3);
        check("t1_ack_cycle", 64'(ack_at), 64'd4);
        check("t1_strobe_count", 64'(strobes2 - s0), 64'd1);
        check("t1_mem", {32'h0, mem2[8'h10]}, 64'hDEAD_BEEF);

        // 2: A read back.
        q2.push_back('{port: 1'b0, err: 1'b0, rdata: 32'hDEAD_BEEF});
        s0 = strobes2;
        run2(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, ack_at, st_at);
        check("t2_ack_cycle", 64'(ack_at), 64'd4);
        check("t2_no_strobe", 64'(strobes2 - s0), 64'd0);

        // 3: ties after reset go A, B, then A again.
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++) begin
            q2.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h0});
            q2.push_back('{port: 1'b1, err: 1'b0, rdata: 32'h0});
            s0 = strobes2;
            fork
                begin
                    int aa, sa;
                    run2(1'b0, 1'b1, 32'h20 + 32'(2 * r), 32'(1 + 2 * r), 1'b0, aa, sa);
                end
                begin
                    int ab, sb;
                    run2(1'b1, 1'b1, 32'h21 + 32'(2 * r), 32'(2 + 2 * r), 1'b0, ab, sb);
                end
            join
            check("t3_strobe_count", 64'(strobes2 - s0), 64'd2);
        end
        check("t3_mem", {mem2[8'h20], mem2[8'h21]}, {32'd1, 32'd2});
        check("t3_mem_tie2", {mem2[8'h22], mem2[8'h23]}, {32'd3, 32'd4});

        // 4: out-of-range B access; word 0 aliases the low bits of 0x10000.
        q2.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h0});
        run2(1'b0, 1'b1, 32'h0, 32'h1234_5678, 1'b0, ack_at, st_at);
        q2.push_back('{port: 1'b1, err: 1'b1, rdata: 32'h0});
        s0 = strobes2;
        run2(1'b1, 1'b0, 32'h1_0000, 32'h0, 1'b0, ack_at, st_at);
        check("t4_rd_ack_cycle", 64'(ack_at), 64'd4);
        q2.push_back('{port: 1'b1, err: 1'b1, rdata: 32'h0});
        run2(1'b1, 1'b1, 32'h1_0000, 32'hBAD0_BAD0, 1'b0, ack_at, st_at);
        check("t4_no_strobe", 64'(strobes2 - s0), 64'd0);
        check("t4_mem0_kept", {32'h0, mem2[8'h00]}, 64'h1234_5678);

        // 5: reset in the middle of an A write.
        s0 = strobes2;
        bus2.a_we = 1'b1; bus2.a_addr = 32'h30; bus2.a_wdata = 32'h55; bus2.a_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_quiet("t5_abort");
        bus2.a_req = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (6) @(negedge clk);
        check("t5_no_strobe", 64'(strobes2 - s0), 64'd0);
        check("t5_mem_unchanged", {32'h0, mem2[8'h30]}, 64'h0);
        @(posedge clk);
        #1;
        q2.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h0});
        run2(1'b0, 1'b1, 32'h30, 32'h66, 1'b1, ack_at, st_at);
        check("t5_fresh_ack_cycle", 64'(ack_at), 64'd4);
        check("t5_fresh_mem", {32'h0, mem2[8'h30]}, 64'h66);

        // 6: zero wait states on the second instance.
        q0.push_back('{port: 1'b1, err: 1'b0, rdata: 32'h0});
        q0.push_back('{port: 1'b1, err: 1'b0, rdata: 32'h0});
        run0(1'b1, 1'b1, 32'h5, 32'hA5A5_0005, ack_at);
        check("t6_wr_ack_cycle", 64'(ack_at), 64'd2);
        run0(1'b1, 1'b1, 32'h6, 32'hA5A5_0006, ack_at);
        q0.push_back('{port: 1'b1, err: 1'b0, rdata: 32'hA5A5_0005});
        q0.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h0});
        q0.push_back('{port: 1'b1, err: 1'b0, rdata: 32'hA5A5_0006});
        ack_b = -1;
        fork
            begin
                bus0.b_we = 1'b0; bus0.b_addr = 32'h5; bus0.b_req = 1'b1;
                @(posedge clk);
                for (int n = 1; n <= 40; n++) begin
                    @(negedge clk);
                    if (bus0.b_ack) begin
                        ack_b = n;
                        break;
                    end
                end
                check("t6_rd_ack_cycle", 64'(ack_b), 64'd2);
                // Keep req up with a new address: the next tie must go to A.
                @(posedge clk);
                #1 bus0.b_addr = 32'h6;
                ack_b = -1;
                for (int n = 1; n <= 40; n++) begin
                    @(negedge clk);
                    if (bus0.b_ack) begin
                        ack_b = n;
                        break;
                    end
                end
                check("t6_second_read_seen", 64'(ack_b > 0), 64'd1);
                @(posedge clk);
                #1 bus0.b_req = 1'b0;
            end
            begin
                @(posedge clk);
                #1;
                run0(1'b0, 1'b1, 32'h40, 32'h77, ack_at);
            end
        join
        check("t6_mem_a", {32'h0, mem0[8'h40]}, 64'h77);

        repeat (4) @(negedge clk);
        check("sb2_drained", 64'(q2.size()), 64'd0);
        check("sb0_drained", 64'(q0.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
